// File: rtl/lpc_pkg.sv
// Shared LPC decode constants: START/SYNC encodings, CYCTYPE fields, capture
// record layout (also used by the serializer) and the decoder state set.
package lpc_pkg;

  localparam logic [3:0] START_TARGET    = 4'b0000;

  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR      = 4'b1010;

  // CYCTYPE/DIR nibble: [3:2] cycle kind, [1] direction (1 = write)
  localparam int         CT_KIND_LSB = 2;
  localparam int         CT_DIR_BIT  = 1;
  localparam logic [1:0] CT_KIND_IO  = 2'b00;
  localparam logic [1:0] CT_KIND_MEM = 2'b01;

  localparam int REC_W        = 48;
  localparam int REC_TYPE_LSB = 44;
  localparam int REC_DROP_BIT = 43;
  localparam int REC_ERR_BIT  = 42;
  localparam int REC_ADDR_LSB = 8;
  localparam int REC_ADDR_W   = 32;
  localparam int REC_DATA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CYCTYPE,
    ST_ADDR,
    ST_WDATA,
    ST_TAR1,
    ST_SYNC,
    ST_RDATA,
    ST_EMIT
  } lpc_state_t;

  function automatic logic [REC_W-1:0] build_record(
    input logic [3:0]            ct,
    input logic                  drop_pending,
    input logic                  sync_err,
    input logic [REC_ADDR_W-1:0] addr,
    input logic [7:0]            data
  );
    logic [REC_W-1:0] rec;
    rec                          = '0;
    rec[REC_TYPE_LSB +: 4]       = ct;
    rec[REC_DROP_BIT]            = drop_pending;
    rec[REC_ERR_BIT]             = sync_err;
    rec[REC_ADDR_LSB +: REC_ADDR_W] = addr;
    rec[REC_DATA_LSB +: 8]       = data;
    return rec;
  endfunction

endpackage

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC sniffer front end: follows target I/O and memory cycles on LAD
// and emits one 48-bit capture record per completed cycle.
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT = 1023,
  parameter int CNT_W        = 10
) (
  input  logic              lpc_clk,
  input  logic              reset,
  input  logic [3:0]        lpc_ad,
  input  logic              lpc_frame_n,
  input  logic              fifo_full,
  output logic [REC_W-1:0]  fifo_data,
  output logic              fifo_write,
  output logic              dropped
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(SYNC_TIMEOUT);

  lpc_state_t       state_q, state_d;
  logic [3:0]       ct_q, ct_d;
  logic [31:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       nib_cnt_q, nib_cnt_d;
  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic             err_q, err_d;
  logic             drop_pending_q, drop_pending_d;
  logic             dropped_q, dropped_d;
  logic [REC_W-1:0] last_rec_q, last_rec_d;
  logic [REC_W-1:0] record;
  logic [CNT_W-1:0] sync_cnt_inc;
  logic             is_write;

  assign record       = build_record(ct_q, drop_pending_q, err_q, addr_q, data_q);
  assign sync_cnt_inc = sync_cnt_q + 1'b1;
  assign is_write     = ct_q[CT_DIR_BIT];

  always_ff @(posedge lpc_clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      ct_q           <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      nib_cnt_q      <= '0;
      sync_cnt_q     <= '0;
      err_q          <= 1'b0;
      drop_pending_q <= 1'b0;
      dropped_q      <= 1'b0;
      last_rec_q     <= '0;
    end else begin
      state_q        <= state_d;
      ct_q           <= ct_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      nib_cnt_q      <= nib_cnt_d;
      sync_cnt_q     <= sync_cnt_d;
      err_q          <= err_d;
      drop_pending_q <= drop_pending_d;
      dropped_q      <= dropped_d;
      last_rec_q     <= last_rec_d;
    end
  end

  // A low LFRAME# overrides whatever cycle was in flight; only START=0000 restarts decoding.
  always_comb begin
    state_d        = state_q;
    ct_d           = ct_q;
    addr_d         = addr_q;
    data_d         = data_q;
    nib_cnt_d      = nib_cnt_q;
    sync_cnt_d     = sync_cnt_q;
    err_d          = err_q;
    drop_pending_d = drop_pending_q;
    dropped_d      = dropped_q;
    last_rec_d     = last_rec_q;
    fifo_write     = 1'b0;

    if (!lpc_frame_n) begin
      state_d = (lpc_ad == START_TARGET) ? ST_CYCTYPE : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: ;

        ST_CYCTYPE: begin
          ct_d   = lpc_ad;
          addr_d = '0;
          err_d  = 1'b0;
          if (lpc_ad[CT_KIND_LSB +: 2] == CT_KIND_IO) begin
            nib_cnt_d = 4'd4;
            state_d   = ST_ADDR;
          end else if (lpc_ad[CT_KIND_LSB +: 2] == CT_KIND_MEM) begin
            nib_cnt_d = 4'd8;
            state_d   = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_ADDR: begin
          addr_d    = {addr_q[27:0], lpc_ad};
          nib_cnt_d = nib_cnt_q - 4'd1;
          if (nib_cnt_q == 4'd1) begin
            nib_cnt_d = 4'd2;
            state_d   = is_write ? ST_WDATA : ST_TAR1;
          end
        end

        ST_WDATA, ST_RDATA: begin
          if (nib_cnt_q == 4'd2) data_d[3:0] = lpc_ad;
          else                   data_d[7:4] = lpc_ad;
          nib_cnt_d = nib_cnt_q - 4'd1;
          if (nib_cnt_q == 4'd1) begin
            nib_cnt_d = 4'd2;
            state_d   = (state_q == ST_WDATA) ? ST_TAR1 : ST_EMIT;
          end
        end

        ST_TAR1: begin
          nib_cnt_d = nib_cnt_q - 4'd1;
          if (nib_cnt_q == 4'd1) begin
            sync_cnt_d = '0;
            state_d    = ST_SYNC;
          end
        end

        // Ready and error both complete the cycle; only the wait codes may stall it.
        ST_SYNC: begin
          sync_cnt_d = sync_cnt_inc;
          case (lpc_ad)
            SYNC_READY, SYNC_ERROR: begin
              err_d     = (lpc_ad == SYNC_ERROR);
              nib_cnt_d = 4'd2;
              state_d   = is_write ? ST_EMIT : ST_RDATA;
            end
            SYNC_SHORT_WAIT, SYNC_LONG_WAIT: begin
              if (sync_cnt_inc == TIMEOUT_CNT) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
          endcase
        end

        ST_EMIT: begin
          state_d = ST_IDLE;
          if (!fifo_full) begin
            fifo_write     = 1'b1;
            last_rec_d     = record;
            drop_pending_d = 1'b0;
          end else begin
            dropped_d      = 1'b1;
            drop_pending_d = 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign fifo_data = fifo_write ? record : last_rec_q;
  assign dropped   = dropped_q;

endmodule
